// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: memory op codes, FSM state
// encodings, reset/enable levels and the UART status MMIO address.
package mem_stage_pkg;

    localparam logic        RST_ENABLE = 1'b1;
    localparam logic        ENABLE     = 1'b1;
    localparam logic        DISABLE    = 1'b0;
    localparam logic [15:0] ZERO_WORD  = 16'h0000;

    localparam logic [1:0] MEM_NOP_OP   = 2'b00;
    localparam logic [1:0] MEM_READ_OP  = 2'b01;
    localparam logic [1:0] MEM_WRITE_OP = 2'b10;

    localparam logic [1:0] MEMST_IDLE   = 2'b00;
    localparam logic [1:0] MEMST_ACCESS = 2'b01;
    localparam logic [1:0] MEMST_DONE   = 2'b10;

    localparam logic [15:0] UART_STATUS_ADDR = 16'hBF01;

endpackage

// File: rtl/mem_stage.sv
// MEM stage: stalls the pipeline around a req/ack data-bus access with timeout.
// Optional UART_STATUS_MMIO_EN: stall-free UART status read at UART_STATUS_ADDR.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] writeData_i,
    input  logic [1:0]  memOp_i,
    input  logic [15:0] memAddr_i,
    input  logic        writeReg_i,
    input  logic [3:0]  writeRegAddr_i,
    input  logic [15:0] busRdata_i,
    input  logic        busAck_i,
`ifdef UART_STATUS_MMIO_EN
    input  logic        uartTxReady_i,
    input  logic        uartDataReady_i,
`endif
    output logic [15:0] writeData_o,
    output logic        writeReg_o,
    output logic [3:0]  writeRegAddr_o,
    output logic        stallReq_o,
    output logic        busReq_o,
    output logic        busWe_o,
    output logic [15:0] busAddr_o,
    output logic [15:0] busWdata_o,
    output logic        busErr_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             busReq_q, busReq_d;
    logic             busWe_q, busWe_d;
    logic [15:0]      busAddr_q, busAddr_d;
    logic [15:0]      busWdata_q, busWdata_d;
    logic             busErr_q, busErr_d;

    logic is_rd, is_wr, is_mmio, bus_op;

    assign is_rd = (memOp_i == MEM_READ_OP);
    assign is_wr = (memOp_i == MEM_WRITE_OP);
`ifdef UART_STATUS_MMIO_EN
    assign is_mmio = (memAddr_i == UART_STATUS_ADDR);
`else
    assign is_mmio = DISABLE;
`endif
    assign bus_op = (is_rd | is_wr) & ~is_mmio;

    // rst is gated in so MEM/WB sees a clean bubble during reset
    always_comb begin
        writeData_o    = writeData_i;
        writeReg_o     = writeReg_i;
        writeRegAddr_o = writeRegAddr_i;
        stallReq_o     = DISABLE;
        if (rst == RST_ENABLE) begin
            writeData_o    = ZERO_WORD;
            writeReg_o     = DISABLE;
            writeRegAddr_o = 4'h0;
        end else begin
            unique case (state_q)
                MEMST_IDLE: begin
                    if (bus_op) begin
                        stallReq_o = ENABLE;
                        writeReg_o = DISABLE;
                    end
`ifdef UART_STATUS_MMIO_EN
                    else if (is_rd && is_mmio) begin
                        writeData_o = {14'b0, uartDataReady_i, uartTxReady_i};
                    end
`endif
                end
                MEMST_ACCESS: begin
                    stallReq_o = ENABLE;
                    writeReg_o = DISABLE;
                end
                MEMST_DONE: begin
                    if (is_rd) writeData_o = rdata_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        busReq_d   = busReq_q;
        busWe_d    = busWe_q;
        busAddr_d  = busAddr_q;
        busWdata_d = busWdata_q;
        busErr_d   = DISABLE;
        unique case (state_q)
            MEMST_IDLE: begin
                if (bus_op) begin
                    busReq_d   = ENABLE;
                    busWe_d    = is_wr;
                    busAddr_d  = memAddr_i;
                    busWdata_d = writeData_i;
                    cnt_d      = '0;
                    state_d    = MEMST_ACCESS;
                end
            end
            MEMST_ACCESS: begin
                // ack wins over timeout when both land in the same cycle
                if (busAck_i) begin
                    rdata_d  = busRdata_i;
                    busReq_d = DISABLE;
                    busWe_d  = DISABLE;
                    state_d  = MEMST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d  = ZERO_WORD;
                    busReq_d = DISABLE;
                    busWe_d  = DISABLE;
                    busErr_d = ENABLE;
                    state_d  = MEMST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEMST_DONE: state_d = MEMST_IDLE;
            default:    state_d = MEMST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q    <= MEMST_IDLE;
            cnt_q      <= '0;
            rdata_q    <= ZERO_WORD;
            busReq_q   <= DISABLE;
            busWe_q    <= DISABLE;
            busAddr_q  <= ZERO_WORD;
            busWdata_q <= ZERO_WORD;
            busErr_q   <= DISABLE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            busReq_q   <= busReq_d;
            busWe_q    <= busWe_d;
            busAddr_q  <= busAddr_d;
            busWdata_q <= busWdata_d;
            busErr_q   <= busErr_d;
        end
    end

    assign busReq_o   = busReq_q;
    assign busWe_o    = busWe_q;
    assign busAddr_o  = busAddr_q;
    assign busWdata_o = busWdata_q;
    assign busErr_o   = busErr_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage that consumes the EX/MEM register outputs and produces write-back info for the MEM/WB register.
- Runs loads and stores over a shared single-port data bus with a req/ack handshake.
- Raises a stall request that freezes the upstream pipeline, including EX/MEM, until the access completes.
- Non-memory ops pass through in zero extra cycles.

Parameters:
- TIMEOUT, 255: maximum ACCESS cycles to wait for busAck_i before the access is aborted (1..255).
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high (`RstEnable = 1'b1`).
- writeData_i  in  16  store data for writes; ALU result for non-memory ops.
- memOp_i  in  2  `MEM_NOP_OP`=00, `MEM_READ_OP`=01, `MEM_WRITE_OP`=10; 11 is reserved and treated as NOP.
- memAddr_i  in  16  word address.
- writeReg_i  in  1  register write enable from EX/MEM.
- writeRegAddr_i  in  4  destination register.
- busRdata_i  in  16  read data, valid in the cycle busAck_i=1.
- busAck_i  in  1  bus completion strobe.
- writeData_o  out  16  to MEM/WB: load data or passthrough.
- writeReg_o  out  1  to MEM/WB.
- writeRegAddr_o  out  4  to MEM/WB.
- stallReq_o  out  1  freezes PC/IF/ID/EX/EX-MEM while high.
- busReq_o  out  1  registered request.
- busWe_o  out  1  registered write enable.
- busAddr_o  out  16  registered address.
- busWdata_o  out  16  registered write data.
- busErr_o  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state←IDLE; counter←0; captured data←0.
  - busReq_o, busWe_o, busErr_o ← 0; busAddr_o, busWdata_o ← 0x0000.
- Outputs while rst is high:
  - stallReq_o=0, writeReg_o=0, writeRegAddr_o=0, writeData_o=0x0000.
  - These apply to combinational outputs too, because rst is gated into them.
- Reset mid-access: the access is abandoned; busReq_o is low after that edge; no write-back occurs.
- FSM states, encoded in 2 bits:
  - IDLE:
    - memOp_i NOP or reserved: outputs pass through combinationally; stallReq_o=0.
    - memOp_i READ or WRITE: stallReq_o=1. Next edge: busReq_o←1, busWe_o←(op==WRITE), busAddr_o←memAddr_i, busWdata_o←writeData_i, counter←0, state←ACCESS.
  - ACCESS:
    - stallReq_o=1; writeReg_o=0 while stalled.
    - busAck_i=1 at an edge: capture busRdata_i; busReq_o←0, busWe_o←0; state←DONE.
    - Otherwise counter increments. When counter==TIMEOUT-1 and no ack: captured←0x0000, busReq_o←0, busErr_o←1 for one cycle, state←DONE.
    - Ack has priority over timeout in the same cycle.
  - DONE:
    - stallReq_o=0.
    - READ: writeData_o=captured data.
    - WRITE: writeData_o=writeData_i.
    - writeReg_o and writeRegAddr_o pass through.
    - Next edge: state←IDLE.
- EX/MEM holds its inputs stable for the whole IDLE→ACCESS→DONE sequence because of the stall.
- Latency: load/store with ack in the first ACCESS cycle takes 3 cycles (2 stall cycles). Each additional bus wait cycle adds 1.
- Back-to-back memory ops: the op following DONE is seen in IDLE and starts a new access with no bubble beyond its own stall.
- busAck_i is ignored in IDLE and DONE.
- Address/data width: 16-bit words, no byte lanes, no alignment checks.

Optional Feature:
- Macro: UART_STATUS_MMIO_EN.
- Defined:
  - Adds inputs uartTxReady_i and uartDataReady_i.
  - READ at address 0xBF01 completes in IDLE with no stall and no bus request.
  - writeData_o = {14'b0, uartDataReady_i, uartTxReady_i}.
  - WRITE to 0xBF01 is dropped as a one-cycle no-op.
- Undefined: 0xBF01 is an ordinary bus address and the ports are absent.

Decomposition:
- defines.v gains:
  - `MEM_READ_OP` and `MEM_WRITE_OP` (alongside the existing `MEM_NOP_OP`).
  - MEMST_IDLE/ACCESS/DONE state encodings.
  - `UART_STATUS_ADDR` = 16'hBF01.
- Reuses `RstEnable`, `ZERO`, `Enable`, `Disable`.
- Single module; no sub-module is warranted. The timeout counter stays inline.

Test Plan:
- Non-memory op (memOp=00, writeData_i=0x1234, writeReg=1, addr=5) → same cycle: writeData_o=0x1234, writeReg_o=1, writeRegAddr_o=5, stallReq_o=0, busReq_o=0.
- Load 0x0040, ack on first ACCESS cycle with rdata 0xBEEF → stallReq_o high 2 cycles; busReq_o high 1 cycle with busWe_o=0 and busAddr_o=0x0040; DONE shows writeData_o=0xBEEF.
- Store 0x0041←0x5A5A, ack after 3 wait cycles → busWe_o=1, busWdata_o=0x5A5A; stall lasts 5 cycles; no further busReq_o in DONE.
- No ack, TIMEOUT=4 → busReq_o high 4 cycles; busErr_o pulses once; writeData_o=0x0000 in DONE; FSM returns to IDLE.
- rst asserted during ACCESS → busReq_o=0 and stallReq_o=0 the next cycle; a following load proceeds normally.
- With UART_STATUS_MMIO_EN, read 0xBF01, txReady=1, dataReady=0 → writeData_o=0x0001 same cycle, stallReq_o=0, busReq_o never asserted.
